// File: rtl/shift_sched_if.sv
// Request/response bundle between the two shift requesters and the shared
// shift sequencer. The master side drives requests; the slave side is the sequencer.
interface shift_sched_if #(
   parameter int WIDTH = 16
);
   logic             REQ0, REQ1;
   logic [1:0]       OP0, OP1;
   logic [WIDTH-1:0] A0, A1;
   logic [WIDTH-1:0] B0, B1;
   logic             ACK0, ACK1;
   logic             DONE0, DONE1;
   logic [WIDTH-1:0] O;
   logic             BUSY;
   logic             OWNER;

   modport master (
      output REQ0, REQ1, OP0, OP1, A0, A1, B0, B1,
      input  ACK0, ACK1, DONE0, DONE1, O, BUSY, OWNER
   );

   modport slave (
      input  REQ0, REQ1, OP0, OP1, A0, A1, B0, B1,
      output ACK0, ACK1, DONE0, DONE1, O, BUSY, OWNER
   );
endinterface

// File: rtl/shift_sched.sv
// Shared multi-cycle shifter (SRL/SLL/SRA/pass) for two requesters with
// round-robin arbitration; each op runs as STEP-bit shift steps.
module shift_sched #(
   parameter int WIDTH = 16,
   parameter int STEP  = 4
) (
   input  logic         CLK,
   input  logic         RSTn,
   shift_sched_if.slave bus
);
   localparam int               RW       = $clog2(WIDTH + 1);
   localparam logic [RW-1:0]    REM_MAX  = RW'(WIDTH);
   localparam logic [RW-1:0]    STEP_AMT = RW'(STEP);
   localparam logic [WIDTH-1:0] SAT_AMT  = WIDTH'(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   typedef struct packed {
      logic [1:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } req_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             owner_q, owner_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [RW-1:0]    rem_q, rem_d;
   logic [WIDTH-1:0] o_q, o_d;
   logic             ack0_q, ack0_d, ack1_q, ack1_d;
   logic             done0_q, done0_d, done1_q, done1_d;
   logic             busy_q, busy_d;

   req_t             req_sel;
   logic             any_req, grant;
   logic [RW-1:0]    req_rem, step_amt, rem_after;
   logic [WIDTH-1:0] shifted;

   // Single requester wins outright; the pointer only breaks ties.
   always_comb begin
      any_req = bus.REQ0 | bus.REQ1;
      grant   = (bus.REQ0 & bus.REQ1) ? ptr_q : bus.REQ1;
      if (grant) begin
         req_sel.op = bus.OP1;
         req_sel.a  = bus.A1;
         req_sel.b  = bus.B1;
      end else begin
         req_sel.op = bus.OP0;
         req_sel.a  = bus.A0;
         req_sel.b  = bus.B0;
      end
      req_rem = (req_sel.b >= SAT_AMT) ? REM_MAX : req_sel.b[RW-1:0];
   end

   // SRA keeps the captured sign bit in the MSB, so >>> fills correctly every step.
   always_comb begin
      step_amt  = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
      rem_after = rem_q - step_amt;
      case (op_q)
         2'b00:   shifted = data_q >> step_amt;
         2'b01:   shifted = data_q << step_amt;
         2'b10:   shifted = $signed(data_q) >>> step_amt;
         default: shifted = data_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (any_req)
               state_d = (req_rem == '0 || req_sel.op == 2'b11) ? S_DONE : S_SHIFT;
         end
         S_SHIFT: begin
            if (rem_after == '0) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Result and DONE are loaded on the edge entering DONE so both are registered.
   always_comb begin
      ptr_d   = ptr_q;
      owner_d = owner_q;
      op_d    = op_q;
      data_d  = data_q;
      rem_d   = rem_q;
      o_d     = o_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      busy_d  = (state_d != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               op_d    = req_sel.op;
               data_d  = req_sel.a;
               rem_d   = req_rem;
               owner_d = grant;
               ptr_d   = ~grant;
               ack0_d  = ~grant;
               ack1_d  = grant;
               if (state_d == S_DONE) begin
                  o_d     = req_sel.a;
                  done0_d = ~grant;
                  done1_d = grant;
               end
            end
         end
         S_SHIFT: begin
            data_d = shifted;
            rem_d  = rem_after;
            if (state_d == S_DONE) begin
               o_d     = shifted;
               done0_d = ~owner_q;
               done1_d = owner_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         op_q    <= 2'b00;
         data_q  <= '0;
         rem_q   <= '0;
         o_q     <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         op_q    <= op_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         o_q     <= o_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.ACK0  = ack0_q;
   assign bus.ACK1  = ack1_q;
   assign bus.DONE0 = done0_q;
   assign bus.DONE1 = done1_q;
   assign bus.O     = o_q;
   assign bus.BUSY  = busy_q;
   assign bus.OWNER = owner_q;
endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: directed plan cases, randomized ops and
// arbitration checked against an arithmetic reference model.
module tb_shift_sched;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   shift_sched_if #(.WIDTH(16)) bus();
   shift_sched #(.WIDTH(16), .STEP(4)) dut (.CLK(clk), .RSTn(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   bit tb_ptr;

   function automatic int ref_amt(input logic [15:0] b);
      return (b > 16'd16) ? 16 : int'(b);
   endfunction

   function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      int amt, ua, sa;
      amt = ref_amt(b);
      ua  = int'(a);
      sa  = int'($signed(a));
      case (op)
         2'd0:    return 16'(ua >> amt);
         2'd1:    return 16'(ua << amt);
         2'd2:    return 16'(sa >>> amt);
         default: return a;
      endcase
   endfunction

   function automatic int ref_k(input logic [1:0] op, input logic [15:0] b);
      if (op == 2'd3) return 0;
      return (ref_amt(b) + 3) / 4;
   endfunction

   task automatic set_req(input bit who, input bit v, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      if (who) begin
         bus.REQ1 = v; bus.OP1 = op; bus.A1 = a; bus.B1 = b;
      end else begin
         bus.REQ0 = v; bus.OP0 = op; bus.A0 = a; bus.B0 = b;
      end
   endtask

   // Drives one request and records what the DUT did over a fixed 7-cycle window.
   task automatic do_op(input bit who, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int ack_c, output int done_c, output int n_done, output int n_other,
                        output logic [15:0] o, output logic own, output logic [7:0] busy_m,
                        output logic [15:0] o_end);
      ack_c = 0; done_c = 0; n_done = 0; n_other = 0; o = '0; own = 1'b0; busy_m = '0;
      @(negedge clk);
      set_req(who, 1'b1, op, a, b);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         busy_m[c] = bus.BUSY;
         if ((who ? bus.ACK1 : bus.ACK0) === 1'b1) begin
            if (ack_c == 0) ack_c = c;
            set_req(who, 1'b0, op, a, b);
         end
         if ((who ? bus.DONE1 : bus.DONE0) === 1'b1) begin
            n_done++;
            if (done_c == 0) begin done_c = c; o = bus.O; own = bus.OWNER; end
         end
         if ((who ? bus.DONE0 : bus.DONE1) === 1'b1) n_other++;
      end
      o_end = bus.O;
      tb_ptr = ~who;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      set_req(1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
      set_req(1'b1, 1'b0, 2'd0, 16'h0, 16'h0);
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.O !== 16'h0000) begin errors++; $display("FAIL reset_o got %h exp 0000", bus.O); end
      checks++;
      if ({bus.BUSY, bus.OWNER, bus.ACK0, bus.ACK1, bus.DONE0, bus.DONE1} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got %b exp 000000", {bus.BUSY, bus.OWNER, bus.ACK0, bus.ACK1, bus.DONE0, bus.DONE1});
      end
      rst_n = 1'b1;
      tb_ptr = 1'b0;
   endtask

   task automatic test_arbitration();
      logic [1:0]  op  [2];
      logic [15:0] a   [2];
      logic [15:0] b   [2];
      int ack_c [2], done_c [2], n_done [2];
      logic [15:0] o_got [2];
      logic own_got [2];
      bit first, second;
      int kf, ks, exp_ack, exp_done;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 2; i++) begin
            op[i] = 2'($urandom_range(0, 3));
            a[i]  = 16'($urandom);
            b[i]  = 16'($urandom_range(0, 20));
            ack_c[i] = 0; done_c[i] = 0; n_done[i] = 0; o_got[i] = '0; own_got[i] = 1'b0;
         end
         first  = tb_ptr;
         second = ~first;
         kf = ref_k(op[first], b[first]);
         ks = ref_k(op[second], b[second]);
         @(negedge clk);
         set_req(1'b0, 1'b1, op[0], a[0], b[0]);
         set_req(1'b1, 1'b1, op[1], a[1], b[1]);
         for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
               if (((i == 0) ? bus.ACK0 : bus.ACK1) === 1'b1) begin
                  if (ack_c[i] == 0) ack_c[i] = c;
                  set_req(i[0], 1'b0, op[i], a[i], b[i]);
               end
               if (((i == 0) ? bus.DONE0 : bus.DONE1) === 1'b1) begin
                  n_done[i]++;
                  if (done_c[i] == 0) begin done_c[i] = c; o_got[i] = bus.O; own_got[i] = bus.OWNER; end
               end
            end
         end
         for (int i = 0; i < 2; i++) begin
            exp_ack  = (i == int'(first)) ? 1 : kf + 3;
            exp_done = (i == int'(first)) ? kf + 1 : kf + 3 + ks;
            checks++;
            if (ack_c[i] !== exp_ack) begin errors++; $display("FAIL arb_ack%0d round %0d got %0d exp %0d", i, r, ack_c[i], exp_ack); end
            checks++;
            if (done_c[i] !== exp_done) begin errors++; $display("FAIL arb_done%0d round %0d got %0d exp %0d", i, r, done_c[i], exp_done); end
            checks++;
            if (n_done[i] !== 1) begin errors++; $display("FAIL arb_done_count%0d round %0d got %0d exp 1", i, r, n_done[i]); end
            checks++;
            if (o_got[i] !== ref_result(op[i], a[i], b[i])) begin
               errors++; $display("FAIL arb_o%0d round %0d got %h exp %h", i, r, o_got[i], ref_result(op[i], a[i], b[i]));
            end
            checks++;
            if (own_got[i] !== i[0]) begin errors++; $display("FAIL arb_owner%0d round %0d got %b exp %b", i, r, own_got[i], i[0]); end
         end
         tb_ptr = first;
      end
   endtask

   task automatic test_directed();
      logic        who [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [1:0]  op  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2, 2'd2};
      logic [15:0] a   [8] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 16'h1234, 16'h8000, 16'h4000};
      logic [15:0] b   [8] = '{16'h0001, 16'h000F, 16'h0010, 16'h0000, 16'h0001, 16'h0005, 16'h0020, 16'h0003};
      logic [15:0] eo  [8] = '{16'h7FFF, 16'h0001, 16'h0000, 16'h0001, 16'h0002, 16'h1234, 16'hFFFF, 16'h0800};
      int          ed  [8] = '{2, 5, 5, 1, 2, 1, 5, 2};
      int ack_c, done_c, n_done, n_other;
      logic [15:0] o, o_end;
      logic own;
      logic [7:0] busy_m, exp_busy;
      for (int t = 0; t < 8; t++) begin
         do_op(who[t], op[t], a[t], b[t], ack_c, done_c, n_done, n_other, o, own, busy_m, o_end);
         exp_busy = 8'(((1 << ed[t]) - 1) << 1);
         checks++;
         if (ack_c !== 1) begin errors++; $display("FAIL dir%0d_ack got %0d exp 1", t, ack_c); end
         checks++;
         if (done_c !== ed[t]) begin errors++; $display("FAIL dir%0d_done got %0d exp %0d", t, done_c, ed[t]); end
         checks++;
         if (o !== eo[t]) begin errors++; $display("FAIL dir%0d_o got %h exp %h", t, o, eo[t]); end
         checks++;
         if (own !== who[t]) begin errors++; $display("FAIL dir%0d_owner got %b exp %b", t, own, who[t]); end
         checks++;
         if (n_done !== 1 || n_other !== 0) begin errors++; $display("FAIL dir%0d_pulses got %0d/%0d exp 1/0", t, n_done, n_other); end
         checks++;
         if (busy_m !== exp_busy) begin errors++; $display("FAIL dir%0d_busy got %b exp %b", t, busy_m, exp_busy); end
      end
   endtask

   task automatic test_random();
      bit who;
      logic [1:0] op;
      logic [15:0] a, b, exp_o, o, o_end;
      int ack_c, done_c, n_done, n_other, exp_done;
      logic own;
      logic [7:0] busy_m, exp_busy;
      for (int t = 0; t < 40; t++) begin
         who = 1'($urandom_range(0, 1));
         op  = 2'($urandom_range(0, 3));
         a   = 16'($urandom);
         b   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
         exp_o    = ref_result(op, a, b);
         exp_done = ref_k(op, b) + 1;
         exp_busy = 8'(((1 << exp_done) - 1) << 1);
         do_op(who, op, a, b, ack_c, done_c, n_done, n_other, o, own, busy_m, o_end);
         checks++;
         if (ack_c !== 1 || done_c !== exp_done) begin
            errors++; $display("FAIL rnd%0d_timing got ack %0d done %0d exp ack 1 done %0d", t, ack_c, done_c, exp_done);
         end
         checks++;
         if (o !== exp_o) begin errors++; $display("FAIL rnd%0d_o op %0d a %h b %h got %h exp %h", t, op, a, b, o, exp_o); end
         checks++;
         if (o_end !== exp_o) begin errors++; $display("FAIL rnd%0d_o_hold got %h exp %h", t, o_end, exp_o); end
         checks++;
         if (own !== who || n_done !== 1 || n_other !== 0) begin
            errors++; $display("FAIL rnd%0d_owner got %b/%0d/%0d exp %b/1/0", t, own, n_done, n_other, who);
         end
         checks++;
         if (busy_m !== exp_busy) begin errors++; $display("FAIL rnd%0d_busy got %b exp %b", t, busy_m, exp_busy); end
      end
   endtask

   task automatic test_reset_midop();
      int ack_c, done_c, n_done, n_other, stray;
      logic [15:0] o, o_end, a, exp_o;
      logic own;
      logic [7:0] busy_m;
      do_op(1'b1, 2'd3, 16'hA5A5, 16'h0000, ack_c, done_c, n_done, n_other, o, own, busy_m, o_end);
      a = 16'($urandom) | 16'h8000;
      @(negedge clk);
      set_req(1'b1, 1'b1, 2'd0, a, 16'h0010);
      @(negedge clk);
      checks++;
      if (bus.ACK1 !== 1'b1) begin errors++; $display("FAIL midop_ack got %b exp 1", bus.ACK1); end
      set_req(1'b1, 1'b0, 2'd0, a, 16'h0010);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.O !== 16'h0000) begin errors++; $display("FAIL midop_reset_o got %h exp 0000", bus.O); end
      checks++;
      if ({bus.BUSY, bus.OWNER, bus.ACK0, bus.ACK1, bus.DONE0, bus.DONE1} !== 6'b0) begin
         errors++;
         $display("FAIL midop_reset_flags got %b exp 000000", {bus.BUSY, bus.OWNER, bus.ACK0, bus.ACK1, bus.DONE0, bus.DONE1});
      end
      stray = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 1) rst_n = 1'b1;
         if (bus.DONE0 === 1'b1 || bus.DONE1 === 1'b1) stray++;
      end
      checks++;
      if (stray !== 0) begin errors++; $display("FAIL midop_no_done got %0d exp 0", stray); end
      tb_ptr = 1'b0;
      exp_o = ref_result(2'd2, 16'h8421, 16'h0002);
      do_op(1'b0, 2'd2, 16'h8421, 16'h0002, ack_c, done_c, n_done, n_other, o, own, busy_m, o_end);
      checks++;
      if (ack_c !== 1 || done_c !== 2) begin errors++; $display("FAIL post_reset_timing got ack %0d done %0d exp 1 2", ack_c, done_c); end
      checks++;
      if (o !== exp_o) begin errors++; $display("FAIL post_reset_o got %h exp %h", o, exp_o); end
   endtask

   initial begin
      test_reset();
      test_arbitration();
      test_directed();
      test_random();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
